// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer.
//   cpu_word      : 32-bit CPU data/address word
//   mem_mode      : memory access width (load sign variants share store lane rules)
//   sb_entry_t    : one buffered store {word address, lane data, lane mask}
//   sb_align_t    : aligned store payload {replicated data, lane mask}
//   store_align   : places right-justified store data into its byte lanes
//   byte_mask_expand : expands a 4-bit lane mask to a 32-bit bit mask
//   merge_lanes   : overwrites the masked lanes of a word with new data
package store_buffer_pkg;

  typedef logic [31:0] cpu_word;

  typedef enum logic [2:0] {
    MM_WORD   = 3'd0,
    MM_HALF   = 3'd1,
    MM_BYTE   = 3'd2,
    MM_HALF_S = 3'd3,
    MM_BYTE_S = 3'd4
  } mem_mode;

  typedef struct packed {
    logic [29:0] waddr;
    cpu_word     data;
    logic [3:0]  mask;
  } sb_entry_t;

  typedef struct packed {
    cpu_word    data;
    logic [3:0] mask;
  } sb_align_t;

  // Little-endian: lane k holds bits 8k+7:8k. Data is replicated across
  // lanes so the mask alone selects what gets written.
  function automatic sb_align_t store_align(cpu_word addr, cpu_word data, mem_mode mode);
    sb_align_t r;
    case (mode)
      MM_HALF, MM_HALF_S: begin
        r.data = {2{data[15:0]}};
        r.mask = addr[1] ? 4'b1100 : 4'b0011;
      end
      MM_BYTE, MM_BYTE_S: begin
        r.data = {4{data[7:0]}};
        r.mask = 4'b0001 << addr[1:0];
      end
      default: begin
        r.data = data;
        r.mask = 4'b1111;
      end
    endcase
    return r;
  endfunction

  function automatic cpu_word byte_mask_expand(logic [3:0] mask);
    cpu_word e;
    e = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      e[8*k +: 8] = {8{mask[k]}};
    end
    return e;
  endfunction

  function automatic cpu_word merge_lanes(cpu_word old_w, cpu_word new_w, logic [3:0] mask);
    cpu_word m;
    m = byte_mask_expand(mask);
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/store_buffer.sv
// store_buffer: FIFO of retired CPU stores feeding data-RAM port 2.
// Partial stores are completed by read-modify-write in the drain cycle:
// the raw RAM word arrives combinationally on ram_rdata, the entry's lanes
// are merged in and the result is written back in the same cycle.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   st_valid/st_ready   store handshake; st_addr/st_data/st_mode payload
//   ld_valid/ld_addr    CPU load probe; ld_conflict flags a pending word
//   ram_busy            CPU load owns port 2, drain suppressed
//   ram_addr/ram_mode/ram_store/ram_wdata  write side of RAM port 2
//   ram_rdata           raw word at ram_addr, same cycle
//   count/empty         occupancy
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  cpu_word                    st_addr,
  input  cpu_word                    st_data,
  input  mem_mode                    st_mode,
  input  logic                       ld_valid,
  input  cpu_word                    ld_addr,
  output logic                       ld_conflict,
  input  logic                       ram_busy,
  output cpu_word                    ram_addr,
  output mem_mode                    ram_mode,
  output logic                       ram_store,
  output cpu_word                    ram_wdata,
  input  cpu_word                    ram_rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  sb_entry_t       r_entries [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  sb_align_t       w_align;
  sb_entry_t       w_new;
  sb_entry_t       w_head;
  sb_entry_t       w_last_ent;
  logic [PW-1:0]   w_last;
  logic [PW-1:0]   w_off;
  logic            w_nonempty;
  logic            w_accept;
  logic            w_drain;
  logic            w_coalesce;
  logic            w_alloc;
  logic            w_conflict;
  logic            w_unused_ld;

  assign w_unused_ld = &{1'b0, ld_addr[1:0]};

  always_comb begin
    w_align        = store_align(st_addr, st_data, st_mode);
    w_new.waddr    = st_addr[31:2];
    w_new.data     = w_align.data;
    w_new.mask     = w_align.mask;

    w_nonempty = (r_count != '0);
    w_last     = r_tail - PW'(1);
    w_head     = r_entries[r_head];
    w_last_ent = r_entries[w_last];

    w_drain  = w_nonempty && !ram_busy;
    w_accept = st_valid && st_ready;
    // With a single entry that is draining, head and tail are the same slot;
    // merging into it would lose the new lanes when it pops, so allocate.
    w_coalesce = w_accept && w_nonempty && (w_last_ent.waddr == w_new.waddr)
                 && !(w_drain && (r_count == ONE_CNT));
    w_alloc = w_accept && !w_coalesce;
  end

  // Entry i is live when its distance from head is below count.
  always_comb begin
    w_conflict = 1'b0;
    w_off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if ((CW'(w_off) < r_count) && (r_entries[i].waddr == ld_addr[31:2])) begin
        w_conflict = 1'b1;
      end
    end
  end

  assign st_ready    = (r_count != FULL_CNT);
  assign empty       = !w_nonempty;
  assign count       = r_count;
  assign ld_conflict = ld_valid && w_conflict;
  assign ram_mode    = MM_WORD;
  assign ram_store   = w_drain;
  assign ram_addr    = w_nonempty ? {w_head.waddr, 2'b00} : '0;
  assign ram_wdata   = w_drain ? merge_lanes(ram_rdata, w_head.data, w_head.mask) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      if (w_coalesce) begin
        r_entries[w_last].data <= merge_lanes(w_last_ent.data, w_new.data, w_new.mask);
        r_entries[w_last].mask <= w_last_ent.mask | w_new.mask;
      end else if (w_alloc) begin
        r_entries[r_tail] <= w_new;
        r_tail            <= r_tail + PW'(1);
      end
      case ({w_alloc, w_drain})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       st_valid;
  logic       st_ready;
  cpu_word    st_addr;
  cpu_word    st_data;
  mem_mode    st_mode;
  logic       ld_valid;
  cpu_word    ld_addr;
  logic       ld_conflict;
  logic       ram_busy;
  cpu_word    ram_addr;
  mem_mode    ram_mode;
  logic       ram_store;
  cpu_word    ram_wdata;
  cpu_word    ram_rdata;
  logic [2:0] count;
  logic       empty;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_mode(st_mode),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .ram_busy(ram_busy), .ram_addr(ram_addr), .ram_mode(ram_mode),
    .ram_store(ram_store), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every drain cycle is compared against the next expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ram_store === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_drain actual=%h required=none", ram_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_addr", ram_addr, mon_e.addr);
        chk("drain_wdata", ram_wdata, mon_e.data);
        chk("drain_mode", 32'(ram_mode), 32'(MM_WORD));
      end
    end
  end

  // Call from #1 after a posedge; returns #1 after the accepting posedge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input mem_mode m);
    int n;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mode  = m;
    n = 0;
    @(negedge clk);
    while (st_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL store_timeout actual=st_ready_low required=accept");
    end
    @(posedge clk);
    #1 st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (empty !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(empty), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_mode   = MM_WORD;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ram_busy  = 1'b0;
    ram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ram_store", 32'(ram_store), 32'd0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_ram_mode", 32'(ram_mode), 32'(MM_WORD));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: word store drains the next cycle
    push_exp(32'h100, 32'hDEADBEEF);
    do_store(32'h100, 32'hDEADBEEF, MM_WORD);
    @(negedge clk);
    chk("t1_ram_store", 32'(ram_store), 32'd1);
    @(posedge clk);
    #1 chk("t1_empty", 32'(empty), 32'd1);

    // 2: byte and half read-modify-write
    ram_rdata = 32'h11223344;
    push_exp(32'h100, 32'hAB223344);
    push_exp(32'h100, 32'hBEEF3344);
    do_store(32'h103, 32'h000000AB, MM_BYTE);
    do_store(32'h102, 32'h0000BEEF, MM_HALF);
    wait_empty("t2_empty");

    // 3: coalescing into the tail entry
    ram_busy = 1'b1;
    do_store(32'h200, 32'h00000011, MM_BYTE);
    do_store(32'h201, 32'h00000022, MM_BYTE);
    chk("t3_count", 32'(count), 32'd1);
    ram_rdata = 32'hFFFFFFFF;
    push_exp(32'h200, 32'hFFFF2211);
    ram_busy = 1'b0;
    wait_empty("t3_empty");

    // 4: full buffer holds the 5th store until the first drain
    ram_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(32'(i * 4), 32'hA0000000 | 32'(i));
      do_store(32'(i * 4), 32'hA0000000 | 32'(i), MM_WORD);
    end
    chk("t4_count_full", 32'(count), 32'd4);
    chk("t4_st_ready_full", 32'(st_ready), 32'd0);
    push_exp(32'h10, 32'h55555555);
    st_valid = 1'b1;
    st_addr  = 32'h10;
    st_data  = 32'h55555555;
    st_mode  = MM_WORD;
    repeat (2) @(posedge clk);
    #1 chk("t4_held_count", 32'(count), 32'd4);
    ram_busy = 1'b0;
    @(negedge clk);
    chk("t4_drain0_store", 32'(ram_store), 32'd1);
    chk("t4_drain0_ready", 32'(st_ready), 32'd0);
    @(negedge clk);
    chk("t4_drain1_store", 32'(ram_store), 32'd1);
    chk("t4_drain1_ready", 32'(st_ready), 32'd1);
    @(posedge clk);
    #1 st_valid = 1'b0;
    chk("t4_count_after_accept", 32'(count), 32'd3);
    @(negedge clk);
    chk("t4_drain2_store", 32'(ram_store), 32'd1);
    @(negedge clk);
    chk("t4_drain3_store", 32'(ram_store), 32'd1);
    @(negedge clk);
    chk("t4_drain4_store", 32'(ram_store), 32'd1);
    @(posedge clk);
    #1;
    wait_empty("t4_empty");

    // 5: load conflict detection
    ram_busy = 1'b1;
    push_exp(32'h300, 32'h12345678);
    do_store(32'h300, 32'h12345678, MM_WORD);
    ld_addr = 32'h302;
    #1 chk("t5_no_ld_valid", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b1;
    #1 chk("t5_conflict_hit", 32'(ld_conflict), 32'd1);
    ld_addr = 32'h304;
    #1 chk("t5_conflict_miss", 32'(ld_conflict), 32'd0);
    ram_busy = 1'b0;
    @(posedge clk);
    #1;
    wait_empty("t5_empty");
    ld_addr = 32'h302;
    #1 chk("t5_conflict_drained", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b0;

    // 6: asynchronous reset discards pending stores
    ram_busy = 1'b1;
    do_store(32'h400, 32'h1, MM_WORD);
    do_store(32'h404, 32'h2, MM_WORD);
    do_store(32'h408, 32'h3, MM_WORD);
    chk("t6_count_pending", 32'(count), 32'd3);
    @(negedge clk);
    #2;
    ram_busy = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    chk("t6_rst_ram_store", 32'(ram_store), 32'd0);
    chk("t6_rst_st_ready", 32'(st_ready), 32'd1);
    chk("t6_rst_ram_addr", ram_addr, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ram_rdata = '0;
    push_exp(32'h500, 32'hCAFEF00D);
    do_store(32'h500, 32'hCAFEF00D, MM_WORD);
    wait_empty("t6_empty");

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
